// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state and requester encodings for the memory arbiter
package mem_arbiter_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_IF   = 2'd1;
   localparam logic [1:0] ST_DRD  = 2'd2;
   localparam logic [1:0] ST_DWR  = 2'd3;

   typedef enum logic [1:0] {
      IDLE     = ST_IDLE,
      IF_BUSY  = ST_IF,
      DRD_BUSY = ST_DRD,
      DWR_BUSY = ST_DWR
   } state_e;

   localparam logic [1:0] RID_NONE  = 2'd0;
   localparam logic [1:0] RID_FETCH = 2'd1;
   localparam logic [1:0] RID_READ  = 2'd2;
   localparam logic [1:0] RID_WRITE = 2'd3;

   function automatic state_e rid_to_state(input logic [1:0] rid);
      state_e st;
      case (rid)
         RID_FETCH: st = IF_BUSY;
         RID_READ:  st = DRD_BUSY;
         RID_WRITE: st = DWR_BUSY;
         default:   st = IDLE;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter for fetch, data read and data write
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        if_flush,
   output logic        if_done,
   output logic [31:0] if_rdata,
   input  logic        d_re,
   input  logic [31:0] d_raddr,
   output logic        d_rdone,
   output logic [31:0] d_rdata,
   input  logic        d_we,
   input  logic [31:0] d_waddr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic        d_wdone,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [3:0]  starve_q, starve_d;
   logic        flush_q, flush_d;
   logic [1:0]  grant_rid;
   logic        fetch_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         starve_q <= '0;
         flush_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         starve_q <= starve_d;
         flush_q  <= flush_d;
      end
   end

   // A starved fetch overrides the fixed write > read > fetch order.
   always_comb begin
      grant_rid = RID_NONE;
      fetch_ok  = if_req && !if_flush;
      if (state_q == IDLE) begin
         if (fetch_ok && (starve_q >= STARVE_LIM)) grant_rid = RID_FETCH;
         else if (d_we)                            grant_rid = RID_WRITE;
         else if (d_re)                            grant_rid = RID_READ;
         else if (fetch_ok)                        grant_rid = RID_FETCH;
      end
   end

   always_comb begin
      starve_d = starve_q;
      if (!if_req)
         starve_d = '0;
      else if (grant_rid == RID_FETCH)
         starve_d = '0;
      else if ((grant_rid == RID_WRITE || grant_rid == RID_READ) && starve_q != 4'hF)
         starve_d = starve_q + 4'd1;
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      flush_d  = flush_q;
      if_done  = 1'b0;
      if_rdata = '0;
      d_rdone  = 1'b0;
      d_rdata  = '0;
      d_wdone  = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_rid != RID_NONE) begin
               state_d = rid_to_state(grant_rid);
               flush_d = 1'b0;
               wdata_d = '0;
               wstrb_d = '0;
               case (grant_rid)
                  RID_WRITE: begin
                     addr_d  = d_waddr;
                     wdata_d = d_wdata;
                     wstrb_d = d_wstrb;
                  end
                  RID_READ: addr_d = d_raddr;
                  default:  addr_d = if_addr;
               endcase
            end
         end
         IF_BUSY: begin
            if (if_flush) flush_d = 1'b1;
            if (mem_ack) begin
               if_done  = !(flush_q || if_flush);
               if_rdata = mem_rdata;
               state_d  = IDLE;
            end
         end
         DRD_BUSY: begin
            if (mem_ack) begin
               d_rdone = 1'b1;
               d_rdata = mem_rdata;
               state_d = IDLE;
            end
         end
         DWR_BUSY: begin
            if (mem_ack) begin
               d_wdone = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Command fields are gated so nothing leaks onto the bus outside a transaction.
   always_comb begin
      mem_req   = (state_q != IDLE);
      mem_we    = (state_q == DWR_BUSY);
      busy      = mem_req;
      mem_addr  = mem_req ? addr_q  : '0;
      mem_wdata = mem_we  ? wdata_q : '0;
      mem_wstrb = mem_we  ? wstrb_q : '0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
   } cmd_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, if_flush, if_done;
   logic [31:0] if_addr, if_rdata;
   logic        d_re, d_rdone;
   logic [31:0] d_raddr, d_rdata;
   logic        d_we, d_wdone;
   logic [31:0] d_waddr, d_wdata;
   logic [3:0]  d_wstrb;
   logic        mem_req, mem_we, mem_ack, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   int   errors = 0;
   int   checks = 0;
   cmd_t exp_q[$];

   always #5 clk = ~clk;

   mem_arbiter #(.STARVE_MAX(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_done(if_done), .if_rdata(if_rdata),
      .d_re(d_re), .d_raddr(d_raddr), .d_rdone(d_rdone), .d_rdata(d_rdata),
      .d_we(d_we), .d_waddr(d_waddr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_wdone(d_wdone),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb);
      cmd_t c;
      c.we = we; c.addr = addr; c.wdata = wdata; c.strb = strb;
      exp_q.push_back(c);
   endtask

   task automatic wait_cmd(input string tag);
      cmd_t e;
      int   n = 0;
      @(negedge clk);
      while (mem_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_req"}, 32'(mem_req), 32'd1);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s_queue: observed empty expected entry", tag);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_we"},    32'(mem_we),    32'(e.we));
         chk({tag, "_addr"},  mem_addr,       e.addr);
         chk({tag, "_wdata"}, mem_wdata,      e.wdata);
         chk({tag, "_wstrb"}, 32'(mem_wstrb), 32'(e.strb));
         chk({tag, "_busy"},  32'(busy),      32'd1);
      end
   endtask

   // kind: 0 fetch, 1 read, 2 write
   task automatic ack(input string tag, input int delay, input logic [31:0] rdata,
                      input int kind, input bit exp_done, input bit drop);
      repeat (delay) begin
         chk({tag, "_hold"}, 32'(mem_req), 32'd1);
         @(negedge clk);
      end
      mem_ack = 1'b1;
      mem_rdata = rdata;
      #1;
      chk({tag, "_if_done"}, 32'(if_done), 32'(kind == 0 && exp_done));
      chk({tag, "_d_rdone"}, 32'(d_rdone), 32'(kind == 1 && exp_done));
      chk({tag, "_d_wdone"}, 32'(d_wdone), 32'(kind == 2 && exp_done));
      if (exp_done && kind == 0) chk({tag, "_if_rdata"}, if_rdata, rdata);
      if (exp_done && kind == 1) chk({tag, "_d_rdata"}, d_rdata, rdata);
      if (drop) begin
         if (kind == 0) if_req = 1'b0;
         if (kind == 1) d_re = 1'b0;
         if (kind == 2) d_we = 1'b0;
      end
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = '0;
      chk({tag, "_idle_after"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      if_req = 0; if_addr = '0; if_flush = 0;
      d_re = 0; d_raddr = '0; d_we = 0; d_waddr = '0; d_wdata = '0; d_wstrb = '0;
      mem_ack = 0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_dones", {29'd0, if_done, d_rdone, d_wdone}, 32'd0);
      rst_n = 1'b1;

      // single fetch, minimum latency
      @(negedge clk);
      if_req = 1; if_addr = 32'h100;
      push(0, 32'h100, 0, 0);
      wait_cmd("fetch");
      ack("fetch", 0, 32'h1234_5678, 0, 1, 1);

      // fetch request coinciding with flush is not granted
      if_req = 1; if_addr = 32'h180; if_flush = 1;
      @(negedge clk);
      chk("flush_grant_req", 32'(mem_req), 32'd0);
      chk("flush_grant_busy", 32'(busy), 32'd0);
      if_flush = 0;
      push(0, 32'h180, 0, 0);
      wait_cmd("fetch2");
      ack("fetch2", 0, 32'h0BAD_F00D, 0, 1, 1);

      // all three at once: write, read, fetch
      d_we = 1; d_waddr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
      d_re = 1; d_raddr = 32'h204;
      if_req = 1; if_addr = 32'h300;
      push(1, 32'h200, 32'hDEAD_BEEF, 4'hF);
      push(0, 32'h204, 0, 0);
      push(0, 32'h300, 0, 0);
      wait_cmd("prio_wr");
      ack("prio_wr", 1, 32'h0, 2, 1, 1);
      wait_cmd("prio_rd");
      ack("prio_rd", 0, 32'hCAFE_F00D, 1, 1, 1);
      wait_cmd("prio_if");
      ack("prio_if", 2, 32'hA5A5_5A5A, 0, 1, 1);

      // starvation: continuous reads, fetch wins the third grant
      d_re = 1; d_raddr = 32'h400;
      if_req = 1; if_addr = 32'h500;
      push(0, 32'h400, 0, 0);
      push(0, 32'h400, 0, 0);
      push(0, 32'h500, 0, 0);
      push(0, 32'h400, 0, 0);
      wait_cmd("starve_rd0");
      ack("starve_rd0", 0, 32'h1111_0000, 1, 1, 0);
      wait_cmd("starve_rd1");
      ack("starve_rd1", 0, 32'h2222_0000, 1, 1, 0);
      wait_cmd("starve_if");
      ack("starve_if", 0, 32'h3333_0000, 0, 1, 1);
      wait_cmd("starve_rd2");
      ack("starve_rd2", 0, 32'h4444_0000, 1, 1, 1);

      // flush during IF_BUSY, ack three cycles later
      if_req = 1; if_addr = 32'h600;
      push(0, 32'h600, 0, 0);
      wait_cmd("flush");
      if_flush = 1; if_req = 0;
      @(negedge clk);
      if_flush = 0;
      chk("flush_busy_hold", 32'(busy), 32'd1);
      repeat (2) @(negedge clk);
      ack("flush", 0, 32'h7777_7777, 0, 0, 0);

      // reset in the middle of a write
      d_we = 1; d_waddr = 32'h700; d_wdata = 32'h1122_3344; d_wstrb = 4'h3;
      push(1, 32'h700, 32'h1122_3344, 4'h3);
      wait_cmd("rstwr");
      rst_n = 0; d_we = 0;
      #1;
      chk("rstwr_mem_req", 32'(mem_req), 32'd0);
      chk("rstwr_mem_we", 32'(mem_we), 32'd0);
      chk("rstwr_busy", 32'(busy), 32'd0);
      chk("rstwr_mem_wdata", mem_wdata, 32'd0);
      chk("rstwr_mem_addr", mem_addr, 32'd0);
      @(negedge clk);
      rst_n = 1; mem_ack = 1;
      #1;
      chk("rstwr_late_wdone", 32'(d_wdone), 32'd0);
      chk("rstwr_late_busy", 32'(busy), 32'd0);
      @(negedge clk);
      mem_ack = 0;
      chk("rstwr_idle", 32'(busy), 32'd0);
      chk("rstwr_idle_req", 32'(mem_req), 32'd0);

      // normal operation resumes
      d_re = 1; d_raddr = 32'h800;
      push(0, 32'h800, 0, 0);
      wait_cmd("post_rst");
      ack("post_rst", 0, 32'h8888_1234, 1, 1, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning the maximum number of consecutive data grants while a fetch waits (range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port if_req, input, 1 bit: fetch request, held until if_done.
REQ-005 SHALL have port if_addr, input, 32 bits: fetch address.
REQ-006 SHALL have port if_flush, input, 1 bit: cancel the outstanding fetch (branch or exception).
REQ-007 SHALL have ports if_done (output, 1 bit: fetch complete) and if_rdata (output, 32 bits: instruction).
REQ-008 SHALL have ports d_re (input, 1 bit), d_raddr (input, 32 bits), d_rdone (output, 1 bit) and d_rdata (output, 32 bits): data read channel.
REQ-009 SHALL have ports d_we (input, 1 bit), d_waddr (input, 32 bits), d_wdata (input, 32 bits), d_wstrb (input, 4 bits) and d_wdone (output, 1 bit): data write channel.
REQ-010 SHALL have ports mem_req, mem_we (output, 1 bit each), mem_addr, mem_wdata (output, 32 bits each) and mem_wstrb (output, 4 bits): single-port memory command.
REQ-011 SHALL have ports mem_ack (input, 1 bit: command complete) and mem_rdata (input, 32 bits: valid in the mem_ack cycle).
REQ-012 SHALL have port busy, output, 1 bit: state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, IF_BUSY, DRD_BUSY and DWR_BUSY.
REQ-014 SHALL arbitrate in IDLE only, with fixed priority write > read > fetch, subject to the starvation rule (REQ-018).
REQ-015 SHALL, on a grant, register the winner's address, wdata and wstrb and enter its BUSY state; a fetch grant with if_flush high in the same cycle SHALL be suppressed.
REQ-016 SHALL, in any BUSY state, assert mem_req with the registered fields, with mem_we=1 only in DWR_BUSY, until the mem_ack cycle.
REQ-017 SHALL, in the mem_ack cycle, pulse the matching done output for one cycle, pass mem_rdata combinationally to if_rdata or d_rdata, and return to IDLE on the next edge; minimum latency is request at cycle 0, done at cycle 1.
REQ-018 SHALL keep a 4-bit starvation counter: increment on each data grant while if_req=1; clear on a fetch grant or when if_req=0; at STARVE_MAX, the next IDLE arbitration with if_req=1 SHALL grant the fetch.
REQ-019 SHALL, on if_flush during IF_BUSY, let the memory transaction complete but suppress if_done for that transaction; if_flush in any other state has no effect.
REQ-020 SHALL drive mem_wstrb=0 and mem_wdata=0 whenever mem_we=0.
REQ-021 SHALL allow a new grant in the IDLE cycle immediately after a done pulse, because requesters drop their request in that cycle.
REQ-022 SHALL treat simultaneous d_re and d_we as two transactions, write first.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously force state IDLE, counter 0, and mem_req, mem_we, all done outputs and busy to 0; all data and address outputs to 0.
REQ-024 SHALL, on reset mid-transaction, abort the transaction with no done pulse; the late mem_ack is ignored.

Structure
REQ-025 SHALL place the state encoding (2-bit localparams) and the requester-ID constants in the shared core package.
REQ-026 SHALL be a single module with no sub-module.

Verification
REQ-027 SHALL cover: if_req, addr 0x100, mem_ack in cycle 1 -> mem_addr=0x100, if_done=1 in cycle 1, if_rdata equals mem_rdata.
REQ-028 SHALL cover: d_we (0x200, 0xDEADBEEF, strb 0xF), d_re (0x204) and if_req all in cycle 0 -> grant order write, read, fetch.
REQ-029 SHALL cover: STARVE_MAX=2 with continuous d_re and if_req -> the third grant is the fetch.
REQ-030 SHALL cover: if_flush in IF_BUSY, mem_ack 3 cycles later -> no if_done, busy=0 afterwards.
REQ-031 SHALL cover: rst_n low during DWR_BUSY -> mem_req=0 immediately, no d_wdone, IDLE after release.
